// File: rtl/image_config_loader_pkg.sv
// Shared definitions for the image configuration loader: FSM encoding,
// header handshake default, field byte-count helper and error-bit positions.
package image_config_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MASK  = 3'd1,
        ST_COUNT = 3'd2,
        ST_PULSE = 3'd3,
        ST_DELAY = 3'd4,
        ST_CSUM  = 3'd5
    } state_t;

    localparam logic [2:0] HANDSHAKE_DEF = 3'b110;

    localparam int ERR_CHECKSUM = 0;
    localparam int ERR_TIMEOUT  = 1;
    localparam int ERR_COUNT    = 2;
    localparam int ERR_W        = 3;

    // Number of stream bytes that carry a field of the given bit width.
    function automatic int field_bytes(input int bits);
        return bits / 8;
    endfunction

endpackage

// File: rtl/image_config_loader_cfg_delay_ram.sv
// Per-channel delay store: one synchronous write port, one synchronous read
// port. Only the read register is reset; the array keeps its contents.
module cfg_delay_ram #(
    parameter int DEPTH_W = 5,
    parameter int DATA_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [DEPTH_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               re,
    input  logic [DEPTH_W-1:0] raddr,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem [0:(2**DEPTH_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/image_config_loader.sv
// Parses the UART configuration stream (header, mask, count, pulse, delays,
// checksum) into shadow registers and per-channel delay RAMs; commits on a good sum.
module image_config_loader
    import image_config_loader_pkg::*;
#(
    parameter int         NUM_CH      = 8,
    parameter int         ALINE_W     = 5,
    parameter int         DELAY_W     = 16,
    parameter int         PULSE_W     = 32,
    parameter logic [2:0] HANDSHAKE   = HANDSHAKE_DEF,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  uart_data,
    input  logic                        new_data,
    input  logic                        wr_en,
    input  logic                        rd_en,
    input  logic [ALINE_W-1:0]          rd_aline,
    output logic                        rd_valid,
    output logic [NUM_CH*DELAY_W-1:0]   ch_delays,
    output logic [NUM_CH-1:0]           channel_select,
    output logic [ALINE_W:0]            aline_count,
    output logic [PULSE_W-1:0]          pulse_shape,
    output logic                        cfg_valid,
    output logic                        load_busy,
    output logic                        err_checksum,
    output logic                        err_timeout,
    output logic                        err_count
);

    localparam int MASK_B  = field_bytes(NUM_CH);
    localparam int PULSE_B = field_bytes(PULSE_W);
    localparam int DLY_B   = field_bytes(DELAY_W);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);

    state_t               state, state_next;
    logic                 new_data_q;
    logic                 byte_stb;
    logic [7:0]           byte_cnt;
    logic [ALINE_W-1:0]   aline_idx;
    logic [CH_W-1:0]      ch_idx;
    logic [7:0]           run_sum;
    logic [TMO_W-1:0]     idle_cnt;
    logic [ERR_W-1:0]     err_q;
    logic [NUM_CH-1:0]    mask_sh;
    logic [ALINE_W:0]     count_sh;
    logic [PULSE_W-1:0]   pulse_sh;
    logic [DELAY_W-1:0]   delay_sr, delay_next;

    logic                 hdr_ok, field_last, count_bad, word_done;
    logic                 last_aline, last_ch, tmo;

    logic                 ram_we;
    logic [CH_W-1:0]      ram_wch;
    logic [ALINE_W-1:0]   ram_waddr;
    logic [DELAY_W-1:0]   ram_wdata;

    logic                 rd_acc, rd_p1;
    logic [ALINE_W-1:0]   rd_addr_q;

    assign byte_stb   = wr_en & new_data & ~new_data_q;
    assign load_busy  = (state != ST_IDLE);
    assign delay_next = DELAY_W'({delay_sr, uart_data});
    assign count_bad  = (uart_data == 8'd0) || (int'(uart_data) > (1 << ALINE_W));
    assign last_aline = ({1'b0, aline_idx} == (count_sh - 1'b1));
    assign last_ch    = (ch_idx == CH_W'(NUM_CH - 1));
    assign tmo        = load_busy && !byte_stb && (idle_cnt == TMO_W'(TIMEOUT_CYC - 1));

    assign err_checksum = err_q[ERR_CHECKSUM];
    assign err_timeout  = err_q[ERR_TIMEOUT];
    assign err_count    = err_q[ERR_COUNT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        hdr_ok     = 1'b0;
        field_last = 1'b1;
        word_done  = 1'b0;
        case (state)
            ST_MASK:  field_last = (byte_cnt == 8'(MASK_B - 1));
            ST_PULSE: field_last = (byte_cnt == 8'(PULSE_B - 1));
            ST_DELAY: field_last = (byte_cnt == 8'(DLY_B - 1));
            default:  field_last = 1'b1;
        endcase
        word_done = (state == ST_DELAY) && byte_stb && field_last;
        case (state)
            ST_IDLE: begin
                if (byte_stb && (uart_data[7:5] == HANDSHAKE)) begin
                    hdr_ok     = 1'b1;
                    state_next = ST_MASK;
                end
            end
            ST_MASK:  if (byte_stb && field_last) state_next = ST_COUNT;
            ST_COUNT: if (byte_stb) state_next = count_bad ? ST_IDLE : ST_PULSE;
            ST_PULSE: if (byte_stb && field_last) state_next = ST_DELAY;
            ST_DELAY: if (word_done && last_aline && last_ch) state_next = ST_CSUM;
            ST_CSUM:  if (byte_stb) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (tmo) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            new_data_q     <= 1'b0;
            byte_cnt       <= '0;
            aline_idx      <= '0;
            ch_idx         <= '0;
            run_sum        <= '0;
            idle_cnt       <= '0;
            err_q          <= '0;
            mask_sh        <= '0;
            count_sh       <= '0;
            pulse_sh       <= '0;
            delay_sr       <= '0;
            channel_select <= '0;
            aline_count    <= '0;
            pulse_shape    <= '0;
            cfg_valid      <= 1'b0;
            ram_we         <= 1'b0;
            ram_wch        <= '0;
            ram_waddr      <= '0;
            ram_wdata      <= '0;
        end else begin
            new_data_q <= new_data;
            ram_we     <= 1'b0;
            idle_cnt   <= (!load_busy || byte_stb) ? '0 : idle_cnt + TMO_W'(1);

            // The checksum covers every byte from the header up to, not including, CSUM.
            if (byte_stb && load_busy && state != ST_CSUM) begin
                run_sum <= run_sum + uart_data;
            end

            if (hdr_ok) begin
                err_q     <= '0;
                cfg_valid <= 1'b0;
                run_sum   <= uart_data;
                byte_cnt  <= '0;
                aline_idx <= '0;
                ch_idx    <= '0;
            end

            if (byte_stb) begin
                case (state)
                    ST_MASK: begin
                        mask_sh  <= NUM_CH'({mask_sh, uart_data});
                        byte_cnt <= field_last ? 8'd0 : byte_cnt + 8'd1;
                    end
                    ST_COUNT: begin
                        byte_cnt <= '0;
                        if (count_bad) begin
                            err_q[ERR_COUNT] <= 1'b1;
                        end else begin
                            count_sh <= (ALINE_W + 1)'(uart_data);
                        end
                    end
                    ST_PULSE: begin
                        pulse_sh <= PULSE_W'({pulse_sh, uart_data});
                        byte_cnt <= field_last ? 8'd0 : byte_cnt + 8'd1;
                    end
                    ST_DELAY: begin
                        delay_sr <= delay_next;
                        byte_cnt <= field_last ? 8'd0 : byte_cnt + 8'd1;
                    end
                    ST_CSUM: begin
                        if (run_sum == uart_data) begin
                            channel_select <= mask_sh;
                            aline_count    <= count_sh;
                            pulse_shape    <= pulse_sh;
                            cfg_valid      <= 1'b1;
                        end else begin
                            err_q[ERR_CHECKSUM] <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // Delays arrive channel-major: all A-lines of channel 0, then channel 1, ...
            if (word_done) begin
                ram_we    <= 1'b1;
                ram_wch   <= ch_idx;
                ram_waddr <= aline_idx;
                ram_wdata <= delay_next;
                if (last_aline) begin
                    aline_idx <= '0;
                    ch_idx    <= ch_idx + CH_W'(1);
                end else begin
                    aline_idx <= aline_idx + ALINE_W'(1);
                end
            end

            if (tmo) begin
                err_q[ERR_TIMEOUT] <= 1'b1;
            end
        end
    end

    // Readback handshake: rd_en is a one-cycle request, taken only while no load
    // is in progress; rd_valid pulses exactly two cycles after an accepted
    // request and ch_delays then holds until the next accepted request.
    assign rd_acc = rd_en & ~load_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_p1     <= 1'b0;
            rd_addr_q <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_p1    <= rd_acc;
            rd_valid <= rd_p1;
            if (rd_acc) begin
                rd_addr_q <= rd_aline;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cfg_delay_ram #(
            .DEPTH_W(ALINE_W),
            .DATA_W (DELAY_W)
        ) u_ram (
            .clk  (clk),
            .rst  (rst),
            .we   (ram_we && (ram_wch == CH_W'(c))),
            .waddr(ram_waddr),
            .wdata(ram_wdata),
            .re   (rd_p1),
            .raddr(rd_addr_q),
            .rdata(ch_delays[c*DELAY_W +: DELAY_W])
        );
    end

endmodule

// File: tb/tb_image_config_loader.sv
// Directed bench for image_config_loader: table of whole-stream loads plus
// hand sequences for readback pipelining, busy-time reads, reset and timeout.
module tb_image_config_loader;

    localparam int NUM_CH  = 8;
    localparam int ALINE_W = 5;
    localparam int DELAY_W = 16;
    localparam int PULSE_W = 32;
    localparam int TMO     = 64;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [7:0]                uart_data;
    logic                      new_data;
    logic                      wr_en;
    logic                      rd_en;
    logic [ALINE_W-1:0]        rd_aline;
    logic                      rd_valid;
    logic [NUM_CH*DELAY_W-1:0] ch_delays;
    logic [NUM_CH-1:0]         channel_select;
    logic [ALINE_W:0]          aline_count;
    logic [PULSE_W-1:0]        pulse_shape;
    logic                      cfg_valid;
    logic                      load_busy;
    logic                      err_checksum;
    logic                      err_timeout;
    logic                      err_count;

    always #5 clk = ~clk;

    image_config_loader #(
        .NUM_CH     (NUM_CH),
        .ALINE_W    (ALINE_W),
        .DELAY_W    (DELAY_W),
        .PULSE_W    (PULSE_W),
        .HANDSHAKE  (3'b110),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_data     (uart_data),
        .new_data      (new_data),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .rd_aline      (rd_aline),
        .rd_valid      (rd_valid),
        .ch_delays     (ch_delays),
        .channel_select(channel_select),
        .aline_count   (aline_count),
        .pulse_shape   (pulse_shape),
        .cfg_valid     (cfg_valid),
        .load_busy     (load_busy),
        .err_checksum  (err_checksum),
        .err_timeout   (err_timeout),
        .err_count     (err_count)
    );

    typedef struct {
        logic [7:0]  mask;
        logic [7:0]  count;
        logic [31:0] pulse;
        logic [3:0]  seed;
        logic [7:0]  csum_adj;
        int          hold;
        logic        exp_cfg_valid;
        logic        exp_err_csum;
        logic        exp_err_count;
        logic [7:0]  exp_sel;
        logic [5:0]  exp_cnt;
        logic [31:0] exp_pulse;
    } load_vec_t;

    load_vec_t         vecs [6];
    int                n_cmp = 0;
    int                n_bad = 0;
    logic [7:0]        run_sum;
    logic [DELAY_W-1:0] exp_ram [NUM_CH][2**ALINE_W];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [NUM_CH*DELAY_W-1:0] exp_line(input int a);
        logic [NUM_CH*DELAY_W-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) v[c*DELAY_W +: DELAY_W] = exp_ram[c][a];
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        uart_data = b;
        new_data  = 1'b1;
        run_sum   = run_sum + b;
        repeat (hold) @(negedge clk);
        new_data = 1'b0;
    endtask

    // Everything after the header; stop_after >= 0 truncates inside the delay field.
    task automatic send_body(input logic [7:0] mask, input logic [7:0] count,
                             input logic [31:0] pulse, input logic [3:0] seed,
                             input logic [7:0] adj, input int hold, input int stop_after);
        int sent;
        sent = 0;
        send_byte(mask, hold);
        send_byte(count, hold);
        if (count == 8'd0 || int'(count) > 32) return;
        for (int i = 3; i >= 0; i--) send_byte(pulse[i*8 +: 8], hold);
        for (int c = 0; c < NUM_CH; c++) begin
            for (int a = 0; a < int'(count); a++) begin
                logic [15:0] w;
                w = {seed, c[3:0], a[7:0]};
                if (stop_after >= 0 && sent >= stop_after) return;
                send_byte(w[15:8], hold);
                sent++;
                if (stop_after >= 0 && sent >= stop_after) return;
                send_byte(w[7:0], hold);
                sent++;
                exp_ram[c][a] = w;
            end
        end
        send_byte(run_sum + adj, hold);
    endtask

    task automatic send_load(input load_vec_t v);
        run_sum = 8'h00;
        send_byte(8'hC0, v.hold);
        send_body(v.mask, v.count, v.pulse, v.seed, v.csum_adj, v.hold, -1);
    endtask

    task automatic read_check(input int a, input string tag);
        @(negedge clk);
        rd_en    = 1'b1;
        rd_aline = a[ALINE_W-1:0];
        @(negedge clk);
        rd_en = 1'b0;
        check($sformatf("%s_rd_valid_t1", tag), rd_valid, 1'b0);
        @(negedge clk);
        check($sformatf("%s_rd_valid_t2", tag), rd_valid, 1'b1);
        check($sformatf("%s_ch_delays_a%0d", tag, a), ch_delays, exp_line(a));
        @(negedge clk);
        check($sformatf("%s_rd_valid_t3", tag), rd_valid, 1'b0);
        check($sformatf("%s_ch_delays_hold", tag), ch_delays, exp_line(a));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_valid"}, rd_valid, 1'b0);
        check({tag, "_ch_delays"}, ch_delays, '0);
        check({tag, "_channel_select"}, channel_select, '0);
        check({tag, "_aline_count"}, aline_count, '0);
        check({tag, "_pulse_shape"}, pulse_shape, '0);
        check({tag, "_cfg_valid"}, cfg_valid, 1'b0);
        check({tag, "_load_busy"}, load_busy, 1'b0);
        check({tag, "_err_checksum"}, err_checksum, 1'b0);
        check({tag, "_err_timeout"}, err_timeout, 1'b0);
        check({tag, "_err_count"}, err_count, 1'b0);
    endtask

    initial begin
        int waited;
        int seen;
        rst       = 1'b1;
        uart_data = 8'h00;
        new_data  = 1'b0;
        wr_en     = 1'b1;
        rd_en     = 1'b0;
        rd_aline  = '0;
        run_sum   = 8'h00;

        // ---- clock/reset ----
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        vecs[0] = '{8'hA5, 8'h02, 32'h0000001F, 4'h0, 8'h00, 1,  1'b1, 1'b0, 1'b0, 8'hA5, 6'd2,  32'h0000001F};
        vecs[1] = '{8'hA5, 8'h02, 32'h0000001F, 4'h0, 8'h01, 1,  1'b0, 1'b1, 1'b0, 8'hA5, 6'd2,  32'h0000001F};
        vecs[2] = '{8'hFF, 8'h00, 32'h00000000, 4'h0, 8'h00, 1,  1'b0, 1'b0, 1'b1, 8'hA5, 6'd2,  32'h0000001F};
        vecs[3] = '{8'hFF, 8'h21, 32'h00000000, 4'h0, 8'h00, 1,  1'b0, 1'b0, 1'b1, 8'hA5, 6'd2,  32'h0000001F};
        vecs[4] = '{8'hA5, 8'h02, 32'h0000001F, 4'h0, 8'h00, 10, 1'b1, 1'b0, 1'b0, 8'hA5, 6'd2,  32'h0000001F};
        vecs[5] = '{8'h3C, 8'h20, 32'hDEADBEEF, 4'h4, 8'h00, 1,  1'b1, 1'b0, 1'b0, 8'h3C, 6'd32, 32'hDEADBEEF};

        // ---- table-driven loads ----
        for (int i = 0; i < 6; i++) begin
            send_load(vecs[i]);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_cfg_valid", i), cfg_valid, vecs[i].exp_cfg_valid);
            check($sformatf("v%0d_err_checksum", i), err_checksum, vecs[i].exp_err_csum);
            check($sformatf("v%0d_err_count", i), err_count, vecs[i].exp_err_count);
            check($sformatf("v%0d_err_timeout", i), err_timeout, 1'b0);
            check($sformatf("v%0d_load_busy", i), load_busy, 1'b0);
            check($sformatf("v%0d_channel_select", i), channel_select, vecs[i].exp_sel);
            check($sformatf("v%0d_aline_count", i), aline_count, vecs[i].exp_cnt);
            check($sformatf("v%0d_pulse_shape", i), pulse_shape, vecs[i].exp_pulse);
            if (vecs[i].exp_cfg_valid) begin
                read_check(0, $sformatf("v%0d", i));
                read_check(int'(vecs[i].count) - 1, $sformatf("v%0d", i));
            end
            if (i == 0) begin
                read_check(1, "v0_a1");
                check("v0_ch3_a1", ch_delays[3*DELAY_W +: DELAY_W], 16'h0301);
            end
        end

        // ---- bytes ignored while wr_en is low ----
        wr_en = 1'b0;
        send_byte(8'hC0, 1);
        @(negedge clk);
        check("wr_en_low_busy", load_busy, 1'b0);
        check("wr_en_low_cfg_valid", cfg_valid, 1'b1);
        wr_en = 1'b1;

        // ---- back-to-back reads ----
        @(negedge clk);
        rd_en = 1'b1; rd_aline = 5'd0;
        @(negedge clk);
        rd_aline = 5'd31;
        check("b2b_valid_t1", rd_valid, 1'b0);
        @(negedge clk);
        rd_en = 1'b0;
        check("b2b_valid_a", rd_valid, 1'b1);
        check("b2b_data_a", ch_delays, exp_line(0));
        @(negedge clk);
        check("b2b_valid_b", rd_valid, 1'b1);
        check("b2b_data_b", ch_delays, exp_line(31));
        @(negedge clk);
        check("b2b_valid_end", rd_valid, 1'b0);

        // ---- read request coinciding with header strobe: both accepted ----
        @(negedge clk);
        uart_data = 8'hC0; new_data = 1'b1; rd_en = 1'b1; rd_aline = 5'd1;
        run_sum = 8'hC0;
        @(negedge clk);
        new_data = 1'b0; rd_en = 1'b0;
        check("same_cyc_busy", load_busy, 1'b1);
        check("same_cyc_cfg_valid", cfg_valid, 1'b0);
        @(negedge clk);
        check("same_cyc_rd_valid", rd_valid, 1'b1);
        check("same_cyc_data", ch_delays, exp_line(1));
        send_body(8'hA5, 8'h02, 32'h1F, 4'h0, 8'h00, 1, -1);
        repeat (3) @(negedge clk);
        check("same_cyc_load_cfg_valid", cfg_valid, 1'b1);
        check("same_cyc_load_sel", channel_select, 8'hA5);
        check("same_cyc_load_cnt", aline_count, 6'd2);

        // ---- read during load is ignored, then reset mid-DELAY ----
        run_sum = 8'h00;
        send_byte(8'hC0, 1);
        @(negedge clk);
        rd_en = 1'b1; rd_aline = 5'd0;
        @(negedge clk);
        rd_en = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rd_valid) seen++;
        end
        check("busy_read_no_valid", seen, 0);
        check("busy_read_busy", load_busy, 1'b1);
        send_body(8'hA5, 8'h02, 32'h1F, 4'h1, 8'h00, 1, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_rst");
        rst = 1'b0;
        send_load(vecs[0]);
        repeat (3) @(negedge clk);
        check("after_rst_cfg_valid", cfg_valid, 1'b1);
        check("after_rst_sel", channel_select, 8'hA5);
        check("after_rst_pulse", pulse_shape, 32'h1F);
        read_check(1, "after_rst");

        // ---- timeout after a truncated delay field ----
        run_sum = 8'h00;
        send_byte(8'hC0, 1);
        send_body(8'hA5, 8'h02, 32'h1F, 4'h0, 8'h00, 1, 5);
        repeat (30) @(negedge clk);
        check("tmo_busy_early", load_busy, 1'b1);
        check("tmo_flag_early", err_timeout, 1'b0);
        waited = 0;
        while (load_busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("tmo_busy_drop", load_busy, 1'b0);
        check("tmo_err_timeout", err_timeout, 1'b1);
        check("tmo_cfg_valid", cfg_valid, 1'b0);
        check("tmo_err_checksum", err_checksum, 1'b0);
        check("tmo_sel_kept", channel_select, 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/image_config_loader.md
Name: image_config_loader

Overview:
- Parametrised successor to the UART image-configuration loader.
- Parses a byte stream from the UART receiver into the following:
  - channel-enable mask
  - active A-line count
  - pulse-shape word
  - per-channel, per-A-line focusing delays
- Delays are stored in per-channel RAMs. The A-line count sets the stream length, and a trailing checksum byte validates it.
- Sits between uart_rx and the pulse/beamformer sequencer. The sequencer reads back one A-line's delays for all channels through a rd_en/rd_valid handshake.

Parameters:
- NUM_CH, 8, channel count. Must be a multiple of 8, max 32.
- ALINE_W, 5, A-line index width. Up to 2**ALINE_W A-lines.
- DELAY_W, 16, delay width. Must be a multiple of 8.
- PULSE_W, 32, pulse-shape width. Must be a multiple of 8.
- HANDSHAKE, 3'b110, value required in header byte bits [7:5].
- TIMEOUT_CYC, 100000, maximum idle clk cycles between bytes while loading.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- uart_data  in  8  received byte.
- new_data  in  1  byte-available level from uart_rx; may stay high for several cycles per byte.
- wr_en  in  1  host-load enable; bytes are ignored when low.
- rd_en  in  1  one-cycle read request.
- rd_aline  in  ALINE_W  A-line to read back.
- rd_valid  out  1  one-cycle pulse; ch_delays is valid from this cycle onward.
- ch_delays  out  NUM_CH*DELAY_W  channel c occupies bits [c*DELAY_W +: DELAY_W].
- channel_select  out  NUM_CH  committed channel mask.
- aline_count  out  ALINE_W+1  committed A-line count.
- pulse_shape  out  PULSE_W  committed pulse shape.
- cfg_valid  out  1  high while a checksum-validated configuration is held.
- load_busy  out  1  high from header accept until return to IDLE.
- err_checksum, err_timeout, err_count  out  1 each  sticky error flags; cleared on the next accepted header.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. RAM contents are not cleared.
- Byte strobe: byte_stb = wr_en & new_data & ~new_data_q, with new_data_q registered. There is exactly one strobe per byte regardless of how long new_data is held.
- Stream format, all multi-byte fields MSB first:
  - HDR: 1 byte, [7:5]==HANDSHAKE, [4:0] ignored.
  - MASK: NUM_CH/8 bytes.
  - COUNT: 1 byte, value N.
  - PULSE: PULSE_W/8 bytes.
  - DELAY: NUM_CH * N * (DELAY_W/8) bytes, channel-major, then A-line ascending.
  - CSUM: 1 byte.
- FSM states: IDLE, MASK, COUNT, PULSE, DELAY, CSUM. A byte counter, A-line index and channel index sequence the fields.
- IDLE transitions:
  - A strobe with a valid header → MASK.
  - On that transition: load_busy=1, cfg_valid=0, all err flags cleared, running sum set to the header byte.
  - Any other byte in IDLE is dropped.
- COUNT check: N==0 or N>2**ALINE_W → set err_count and go to IDLE. Shadow registers are not committed.
- Shadow registers: MASK, COUNT and PULSE bytes go to shadow registers. The committed outputs update only on a good checksum.
- DELAY writes: each complete delay word is written to cfg_delay_ram[ch] at address aline, one cycle after its last byte. After the last channel and A-line → CSUM.
- CSUM byte:
  - sum8 of all preceding bytes == CSUM → commit shadows, cfg_valid=1.
  - Otherwise → err_checksum=1, cfg_valid stays 0.
  - Both cases go to IDLE with load_busy=0.
- Timeout: in any non-IDLE state, an idle counter reaches TIMEOUT_CYC with no strobe → err_timeout, go to IDLE. The counter resets on each strobe.
- Readback:
  - rd_en is accepted only when load_busy==0; it is ignored otherwise (no rd_valid).
  - Latency is 2 cycles: rd_aline registered, then synchronous RAM read. rd_valid pulses at T+2 for rd_en at T.
  - ch_delays holds its value until the next accepted read.
  - Back-to-back rd_en is legal and fully pipelined.
  - rd_aline >= aline_count returns stale RAM data; no error is flagged.
- Same-cycle events: if rd_en coincides with a header strobe, the read is accepted and the header is also accepted.
- Reset mid-load: returns to IDLE, outputs zero. Partially written RAM words remain but are never flagged valid.

Decomposition:
- Shared defines (store_configs_defines.v successor) hold:
  - state encodings
  - HANDSHAKE default
  - field byte-count macros
  - error-bit positions
- Sub-module: cfg_delay_ram, parameters DEPTH_W and DATA_W, with one synchronous write port and one synchronous read port. One instance per channel via generate.

Test Plan:
- Default params. Stream C0, A5, 02, 00 00 00 1F, 32 delay bytes with ch c / aline a = {c,a} (e.g. 0x0301), correct csum → cfg_valid=1, channel_select=A5, aline_count=2, pulse_shape=0x1F. Then rd_en with rd_aline=1 → rd_valid at +2 cycles, ch3 delay=0x0301.
- Same stream with csum off by 1 → err_checksum=1, cfg_valid=0, channel_select keeps its prior value.
- Header C0, FF, then COUNT=00, and separately COUNT=21 → err_count=1, FSM in IDLE.
- Stop after 5 delay bytes and wait TIMEOUT_CYC cycles → err_timeout=1, load_busy=0.
- new_data held high 10 cycles per byte → exactly one byte consumed per assertion; same results as the first scenario.
- rd_en during load → no rd_valid. Assert rst mid-DELAY → all outputs 0 the next cycle; a following valid load succeeds.
